hello_monitor: RTL and testbench
================================

HELLO_MONITOR -- requirements
Module: hello_monitor

Interface
REQ-001 Parameter STEP, default 1: expected increment between consecutive valid samples, taken modulo 256.
REQ-002 Parameter LOCK_N, default 4, legal range 1..15: number of consecutive matching samples needed to lock.
REQ-003 Port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port io_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port io_in, input, 8 bits: sample stream from the Hello counter output.
REQ-006 Port io_in_valid, input, 1 bit: io_in is sampled on edges where this is high.
REQ-007 Port io_locked, output, 1 bit: high while the stream is tracked in sequence.
REQ-008 Port io_err, output, 1 bit: one-cycle pulse per mismatch detected while locked.
REQ-009 Port io_err_cnt, output, 8 bits: saturating count of locked-state mismatches.
REQ-010 Port io_sample_cnt, output, 16 bits: count of valid samples (see Configuration).

Function
REQ-011 States SHALL be IDLE, SYNC and LOCKED; an 8-bit expected register and a 4-bit match counter SHALL exist.
REQ-012 A cycle with io_in_valid low SHALL leave all state, counters and outputs unchanged, except that io_err returns to 0.
REQ-013 In IDLE, a valid sample SHALL set expected = io_in + STEP (mod 256), set match = 0 and move to SYNC.
REQ-014 In SYNC, a valid sample equal to expected SHALL increment match and advance expected by STEP.
REQ-015 In SYNC, when the increment makes match reach LOCK_N, the block SHALL move to LOCKED.
REQ-016 In SYNC, a mismatching sample SHALL set expected = io_in + STEP and match = 0, with no error pulse and no change to io_err_cnt.
REQ-017 In LOCKED, a matching sample SHALL advance expected by STEP.
REQ-018 In LOCKED, a mismatch SHALL pulse io_err for exactly one cycle, increment io_err_cnt, set expected = io_in + STEP and match = 0, and move to SYNC.
REQ-019 io_err_cnt SHALL hold at 0xFF once it reaches 0xFF.
REQ-020 io_sample_cnt SHALL increment on every valid sample in every state and wrap from 0xFFFF to 0.
REQ-021 Expected-value arithmetic SHALL be 8 bits and wrap: 0xFF + 1 = 0x00 counts as a match.
REQ-022 All outputs SHALL be registered; io_locked is high from the cycle after the edge that enters LOCKED, and io_err is high in the cycle after the edge that samples the mismatch.

Reset
REQ-023 With io_rst high at an edge: state = IDLE, expected = 0, match = 0, and all outputs = 0 in the following cycle.
REQ-024 Reset SHALL take priority over a valid sample on the same edge, including mid-LOCKED; that sample is discarded.

Configuration
REQ-025 Macro HELLO_MONITOR_STATS_EN defined: io_sample_cnt is implemented as in REQ-020.
REQ-026 Macro HELLO_MONITOR_STATS_EN undefined: no sample counter register is built, io_sample_cnt is tied to 0, and all other behaviour is identical.

Structure
REQ-027 Package hello_pkg SHALL hold the state enumeration, the data width (8), the error-count width (8) and the sample-count width (16).
REQ-028 Sub-module hello_seq_pred SHALL hold the expected register and STEP adder and report a match; hello_monitor owns the FSM and the counters.

Verification (STEP=1, LOCK_N=4, valid every cycle unless stated)
REQ-029 Lock: reset, then send 0x10,0x11,0x12,0x13,0x14 -> io_locked high in the cycle after 0x14 is sampled; io_err_cnt = 0.
REQ-030 Wrap: send 0xFC through 0x02 -> lock achieved, no io_err pulse at the 0xFF->0x00 step.
REQ-031 Error and relock: once locked on 0x20, send 0x55 instead of 0x21 -> io_err high for 1 cycle, io_err_cnt = 1, io_locked low; then 0x56..0x59 -> relocked, io_err_cnt stays 1.
REQ-032 Gaps: lock sequence with io_in_valid low for 3 cycles between each sample -> same result as REQ-029; io_sample_cnt = 5 (macro defined).
REQ-033 Saturation: 300 alternating lock/mismatch episodes -> io_err_cnt = 0xFF, never wraps.
REQ-034 Reset while locked, with a valid sample on the reset edge -> next cycle io_locked = 0, io_err = 0, io_err_cnt = 0, io_sample_cnt = 0.

Source files
------------

// File: rtl/hello_pkg.sv
// hello_pkg: shared types and widths for the Hello counter stream monitor.
// Holds the monitor state enumeration and the data, match, error-count and
// sample-count widths.
package hello_pkg;

    localparam int DATA_W       = 8;
    localparam int ERR_CNT_W    = 8;
    localparam int SAMPLE_CNT_W = 16;
    localparam int MATCH_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/hello_seq_pred.sv
// hello_seq_pred: sequence predictor for the Hello monitor.
// Keeps the value the next valid sample should carry. On load it restarts from
// the current sample; on advance it steps by STEP. All arithmetic is 8-bit, so
// it wraps and 0xFF followed by 0x00 is a match when STEP is 1.
module hello_seq_pred
    import hello_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] expected,
    output logic              match
);

    // STEP is taken modulo 256 by truncating it to the data width.
    localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);

    logic [DATA_W-1:0] expected_reg;

    // Expected-value register: restart from the sample or step forward.
    always_ff @(posedge clock) begin
        if (rst) begin
            expected_reg <= '0;
        end else if (load) begin
            expected_reg <= sample + STEP_W;
        end else if (advance) begin
            expected_reg <= expected_reg + STEP_W;
        end
    end

    assign expected = expected_reg;
    assign match    = (sample == expected_reg);

endmodule

// File: rtl/hello_monitor.sv
// hello_monitor: tracks the Hello counter output stream.
// FSM IDLE -> SYNC -> LOCKED. The block locks after LOCK_N consecutive in-step
// samples and reports every break in sequence seen while locked.
// Optional feature: define HELLO_MONITOR_STATS_EN to build the 16-bit valid
// sample counter. Without it io_sample_cnt is tied to zero.
module hello_monitor
    import hello_pkg::*;
#(
    parameter int STEP   = 1,
    parameter int LOCK_N = 4
) (
    input  logic                    clock,
    input  logic                    io_rst,
    input  logic [DATA_W-1:0]       io_in,
    input  logic                    io_in_valid,
    output logic                    io_locked,
    output logic                    io_err,
    output logic [ERR_CNT_W-1:0]    io_err_cnt,
    output logic [SAMPLE_CNT_W-1:0] io_sample_cnt
);

    localparam logic [MATCH_W-1:0]   LOCK_N_W = MATCH_W'(LOCK_N);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    state_t                 state_reg, state_next;
    logic [MATCH_W-1:0]     match_cnt_reg, match_cnt_next;
    logic [MATCH_W-1:0]     match_cnt_inc;
    logic                   locked_reg, locked_next;
    logic                   err_reg, err_next;
    logic [ERR_CNT_W-1:0]   err_cnt_reg, err_cnt_next;

    logic                   pred_load;
    logic                   pred_advance;
    logic                   pred_match;
    logic [DATA_W-1:0]      pred_expected;

    hello_seq_pred #(
        .STEP (STEP)
    ) u_pred (
        .clock    (clock),
        .rst      (io_rst),
        .load     (pred_load),
        .advance  (pred_advance),
        .sample   (io_in),
        .expected (pred_expected),
        .match    (pred_match)
    );

    assign match_cnt_inc = match_cnt_reg + 1'b1;

    // Next-state, predictor control and registered-output next values.
    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        err_next       = 1'b0;
        pred_load      = 1'b0;
        pred_advance   = 1'b0;

        if (io_in_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    pred_load      = 1'b1;
                    match_cnt_next = '0;
                    state_next     = ST_SYNC;
                end
                ST_SYNC: begin
                    if (pred_match) begin
                        pred_advance   = 1'b1;
                        match_cnt_next = match_cnt_inc;
                        if (match_cnt_inc == LOCK_N_W) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        // Still hunting for sequence: resync silently.
                        pred_load      = 1'b1;
                        match_cnt_next = '0;
                    end
                end
                ST_LOCKED: begin
                    if (pred_match) begin
                        pred_advance = 1'b1;
                    end else begin
                        pred_load      = 1'b1;
                        match_cnt_next = '0;
                        state_next     = ST_SYNC;
                        err_next       = 1'b1;
                        if (err_cnt_reg != ERR_MAX) begin
                            err_cnt_next = err_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next     = ST_IDLE;
                    match_cnt_next = '0;
                end
            endcase
        end

        locked_next = (state_next == ST_LOCKED);
    end

    // State and output registers; reset wins over a sample on the same edge.
    always_ff @(posedge clock) begin
        if (io_rst) begin
            state_reg     <= ST_IDLE;
            match_cnt_reg <= '0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            locked_reg    <= locked_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign io_locked  = locked_reg;
    assign io_err     = err_reg;
    assign io_err_cnt = err_cnt_reg;

`ifdef HELLO_MONITOR_STATS_EN
    logic [SAMPLE_CNT_W-1:0] sample_cnt_reg;

    // Free-running count of valid samples, wrapping at 16 bits.
    always_ff @(posedge clock) begin
        if (io_rst) begin
            sample_cnt_reg <= '0;
        end else if (io_in_valid) begin
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
        end
    end

    assign io_sample_cnt = sample_cnt_reg;
`else
    assign io_sample_cnt = '0;
`endif

endmodule

// File: tb/tb_hello_monitor.sv
// tb_hello_monitor: directed bench for hello_monitor (STEP=1, LOCK_N=4).
// A reference model written in terms of "previous sample" and "run length"
// is checked against the DUT every cycle, alongside literal expectations.
module tb_hello_monitor;

    localparam int STEP   = 1;
    localparam int LOCK_N = 4;

    logic        clock = 1'b0;
    logic        io_rst;
    logic [7:0]  io_in;
    logic        io_in_valid;
    logic        io_locked;
    logic        io_err;
    logic [7:0]  io_err_cnt;
    logic [15:0] io_sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hello_monitor #(
        .STEP   (STEP),
        .LOCK_N (LOCK_N)
    ) dut (
        .clock         (clock),
        .io_rst        (io_rst),
        .io_in         (io_in),
        .io_in_valid   (io_in_valid),
        .io_locked     (io_locked),
        .io_err        (io_err),
        .io_err_cnt    (io_err_cnt),
        .io_sample_cnt (io_sample_cnt)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit         m_started;
    logic [7:0] m_prev;
    int         m_run;
    bit         m_locked;
    bit         m_err;
    int         m_err_cnt;
    int         m_sample_cnt;
    bit         cmp_en = 1'b0;

    always @(posedge clock) begin
        if (io_rst) begin
            m_started    = 1'b0;
            m_prev       = 8'h00;
            m_run        = 0;
            m_locked     = 1'b0;
            m_err        = 1'b0;
            m_err_cnt    = 0;
            m_sample_cnt = 0;
            cmp_en       = 1'b1;
        end else begin
            m_err = 1'b0;
            if (io_in_valid) begin
                m_sample_cnt = (m_sample_cnt + 1) % 65536;
                if (!m_started) begin
                    m_started = 1'b1;
                    m_run     = 0;
                end else if (io_in == 8'(m_prev + STEP)) begin
                    if (!m_locked) begin
                        m_run = m_run + 1;
                        if (m_run >= LOCK_N) m_locked = 1'b1;
                    end
                end else begin
                    if (m_locked) begin
                        m_err = 1'b1;
                        if (m_err_cnt < 255) m_err_cnt = m_err_cnt + 1;
                    end
                    m_locked = 1'b0;
                    m_run    = 0;
                end
                m_prev = io_in;
            end
        end
    end

    function automatic int exp_sample_cnt(input int cnt);
`ifdef HELLO_MONITOR_STATS_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_locked",     {31'b0, io_locked},   {31'b0, m_locked});
            check("cyc_err",        {31'b0, io_err},      {31'b0, m_err});
            check("cyc_err_cnt",    {24'b0, io_err_cnt},  m_err_cnt);
            check("cyc_sample_cnt", {16'b0, io_sample_cnt}, exp_sample_cnt(m_sample_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        io_in       = v;
        io_in_valid = 1'b1;
        tick();
        $display("[TB] sample 0x%02h -> locked=%0d err=%0d err_cnt=%0d sample_cnt=%0d",
                 v, io_locked, io_err, io_err_cnt, io_sample_cnt);
    endtask

    task automatic gap(input int n);
        io_in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        io_rst      = 1'b1;
        io_in_valid = 1'b0;
        tick();
        tick();
        io_rst = 1'b0;
    endtask

    logic [7:0] v;

    initial begin
        io_rst      = 1'b1;
        io_in       = 8'h00;
        io_in_valid = 1'b0;
        tick();
        tick();
        io_rst = 1'b0;

        // Reset state
        check("rst_locked",     {31'b0, io_locked},     0);
        check("rst_err",        {31'b0, io_err},        0);
        check("rst_err_cnt",    {24'b0, io_err_cnt},    0);
        check("rst_sample_cnt", {16'b0, io_sample_cnt}, 0);

        // Lock on 0x10..0x14
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
        check("lock_not_yet", {31'b0, io_locked}, 0);
        send(8'h14);
        check("lock_locked",  {31'b0, io_locked}, 1);
        check("lock_err_cnt", {24'b0, io_err_cnt}, 0);

        // Wrap 0xFC..0x02: locked by 0x00, no error at the wrap
        gap(1);
        do_reset();
        for (int i = 32'hFC; i <= 32'h102; i++) begin
            send(8'(i));
            if (i == 32'h100) check("wrap_locked_at_00", {31'b0, io_locked}, 1);
        end
        check("wrap_locked",  {31'b0, io_locked}, 1);
        check("wrap_err_cnt", {24'b0, io_err_cnt}, 0);

        // Error and relock
        gap(1);
        do_reset();
        for (int i = 32'h1C; i <= 32'h20; i++) send(8'(i));
        check("err_pre_locked", {31'b0, io_locked}, 1);
        send(8'h55);
        check("err_pulse",   {31'b0, io_err},     1);
        check("err_cnt_1",   {24'b0, io_err_cnt}, 1);
        check("err_unlock",  {31'b0, io_locked},  0);
        send(8'h56);
        check("err_one_cycle", {31'b0, io_err}, 0);
        for (int i = 32'h57; i <= 32'h59; i++) send(8'(i));
        check("relock",        {31'b0, io_locked},  1);
        check("relock_errcnt", {24'b0, io_err_cnt}, 1);

        // Gaps of 3 invalid cycles between samples
        gap(1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h10 + i));
            gap(3);
        end
        check("gap_locked",     {31'b0, io_locked},     1);
        check("gap_err_cnt",    {24'b0, io_err_cnt},    0);
        check("gap_sample_cnt", {16'b0, io_sample_cnt}, exp_sample_cnt(5));

        // Reset while locked (after one error), valid sample on the reset edge
        send(8'h99);
        check("pre_rst_err_cnt", {24'b0, io_err_cnt}, 1);
        for (int i = 32'h9A; i <= 32'h9D; i++) send(8'(i));
        check("pre_rst_locked", {31'b0, io_locked}, 1);
        io_rst      = 1'b1;
        io_in       = 8'h9E;
        io_in_valid = 1'b1;
        tick();
        check("rst_lk_locked",     {31'b0, io_locked},     0);
        check("rst_lk_err",        {31'b0, io_err},        0);
        check("rst_lk_err_cnt",    {24'b0, io_err_cnt},    0);
        check("rst_lk_sample_cnt", {16'b0, io_sample_cnt}, 0);
        io_rst      = 1'b0;
        io_in_valid = 1'b0;
        tick();

        // Saturation: 300 lock/mismatch episodes
        do_reset();
        v = 8'h00;
        for (int k = 0; k < 5; k++) send(8'(v + k));
        v = v + 8'd4;
        for (int e = 0; e < 300; e++) begin
            v = v + 8'h40;
            send(v);
            for (int k = 1; k <= 4; k++) send(8'(v + k));
            v = v + 8'd4;
            if (e == 254) check("sat_reach_ff", {24'b0, io_err_cnt}, 32'hFF);
        end
        check("sat_err_cnt", {24'b0, io_err_cnt}, 32'hFF);
        check("sat_locked",  {31'b0, io_locked},  1);

        gap(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
